// File: rtl/dot_product_stream_if.sv
// Element/result handshake bundle for dot_product_stream.
// master: the environment (source of din, sink of dout); slave: the engine.
interface dot_product_stream_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned VECTOR_SIZE = 6
);
  localparam int unsigned OUT_WIDTH = 2 * DATA_WIDTH + $clog2(VECTOR_SIZE);

  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic                  din_ready;
  logic [OUT_WIDTH-1:0]  dout;
  logic                  dout_valid;
  logic                  dout_ready;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid
  );
endinterface

// File: rtl/dot_product_stream.sv
// Streaming dot-product engine: loads vector A, then multiply-accumulates against B.
// Optional feature macro: DOT_PRODUCT_SIGNED_EN (two's-complement operands and result).
module dot_product_stream #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned VECTOR_SIZE = 6
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush,
  dot_product_stream_if.slave    bus,
  output logic                   run
);
  localparam int unsigned OUT_WIDTH  = 2 * DATA_WIDTH + $clog2(VECTOR_SIZE);
  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int unsigned EXT_WIDTH  = OUT_WIDTH - PROD_WIDTH;
  localparam int unsigned IDX_WIDTH  = $clog2(VECTOR_SIZE);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(VECTOR_SIZE - 1);

  typedef enum logic {LOAD_A, MAC_B} phase_t;

  phase_t                 phase_q, phase_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [OUT_WIDTH-1:0]   acc_q, acc_d;
  logic [OUT_WIDTH-1:0]   dout_q, dout_d;
  logic                   dout_valid_q, dout_valid_d;

  logic [DATA_WIDTH-1:0]  a_buf [VECTOR_SIZE];
  logic [DATA_WIDTH-1:0]  a_sel;
  logic [PROD_WIDTH-1:0]  prod;
  logic [OUT_WIDTH-1:0]   prod_ext;
  logic [OUT_WIDTH-1:0]   sum;
  logic                   last_b;
  logic                   in_ready;
  logic                   hs;
  logic                   a_we;

  // Only the final B element stalls, and only behind an unconsumed result.
  assign last_b    = (phase_q == MAC_B) && (idx_q == LAST_IDX);
  assign in_ready  = !(last_b && dout_valid_q && !bus.dout_ready);
  assign hs        = bus.din_valid && in_ready && !flush;
  assign a_we      = hs && (phase_q == LOAD_A);
  assign a_sel     = a_buf[idx_q];

`ifdef DOT_PRODUCT_SIGNED_EN
  assign prod     = $signed({{DATA_WIDTH{a_sel[DATA_WIDTH-1]}}, a_sel}) *
                    $signed({{DATA_WIDTH{bus.din[DATA_WIDTH-1]}}, bus.din});
  assign prod_ext = {{EXT_WIDTH{prod[PROD_WIDTH-1]}}, prod};
`else
  assign prod     = {{DATA_WIDTH{1'b0}}, a_sel} * {{DATA_WIDTH{1'b0}}, bus.din};
  assign prod_ext = {{EXT_WIDTH{1'b0}}, prod};
`endif

  assign sum = acc_q + prod_ext;

  assign bus.din_ready  = in_ready;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign run            = (phase_q == LOAD_A) && (idx_q == '0);

  // A buffer holds data only; it needs no reset value.
  always_ff @(posedge clk) begin
    if (a_we) a_buf[idx_q] <= bus.din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_q      <= LOAD_A;
      idx_q        <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Next-state: flush aborts the pair; a final B handshake publishes the result.
  always_comb begin
    phase_d      = phase_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q && !bus.dout_ready;

    if (flush) begin
      phase_d = LOAD_A;
      idx_d   = '0;
      acc_d   = '0;
    end else if (hs) begin
      unique case (phase_q)
        LOAD_A: begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            phase_d = MAC_B;
          end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
        MAC_B: begin
          if (idx_q == LAST_IDX) begin
            dout_d       = sum;
            dout_valid_d = 1'b1;
            acc_d        = '0;
            idx_d        = '0;
            phase_d      = LOAD_A;
          end else begin
            acc_d = sum;
            idx_d = idx_q + IDX_WIDTH'(1);
          end
        end
        default: phase_d = LOAD_A;
      endcase
    end
  end
endmodule
